// File: rtl/sb_trans_rx_fsm.sv
// sb_trans_rx_fsm -- sideband transaction receiver.
// Deserializes the SBRX line (10-bit symbols: start 0, 8 data LSB first, stop 1),
// parses DLE/STX/ETX AT frames and DLE/LSE/CLSE LT frames, reports each frame.
// Optional feature macro: SB_RX_CRC_CHECK_EN (CRC-16 check of AT frames).
// Ports:
//   sb_clk        sideband clock, one bit time per cycle
//   rst           asynchronous active-low reset
//   sbrx          serial sideband line, idle high
//   trans_rcvd    decoded type (2 AT cmd, 3 AT rsp, 4 LT), valid with rx_valid
//   rx_valid      one-cycle pulse, frame accepted
//   rx_addr       AT address byte
//   rx_len        AT length byte (bit7 write, [6:0] count)
//   rx_data       AT data, first byte in [7:0]
//   rx_err        one-cycle pulse, frame discarded
//   disconnected  sbrx held low for DISC_CYCLES synchronized samples
module sb_trans_rx_fsm #(
  parameter int DISC_CYCLES = 32
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        sbrx,
  output logic [2:0]  trans_rcvd,
  output logic        rx_valid,
  output logic [7:0]  rx_addr,
  output logic [7:0]  rx_len,
  output logic [23:0] rx_data,
  output logic        rx_err,
  output logic        disconnected
);
  localparam int DCW = $clog2(DISC_CYCLES + 1);
  localparam logic [7:0] SYM_DLE  = 8'hFE;
  localparam logic [7:0] SYM_CMD  = 8'h05;
  localparam logic [7:0] SYM_RSP  = 8'h04;
  localparam logic [7:0] SYM_LSE  = 8'h80;
  localparam logic [7:0] SYM_CLSE = 8'h7F;
  localparam logic [7:0] SYM_ETX  = 8'h40;
  localparam logic [2:0] TR_CMD = 3'd2;
  localparam logic [2:0] TR_RSP = 3'd3;
  localparam logic [2:0] TR_LT  = 3'd4;

  // synchronizer, resets to idle-high
  logic [1:0] sync;
  logic       sbrx_s;
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], sbrx};
  assign sbrx_s = sync[1];

  // disconnect detect: consecutive low samples, saturating
  logic [DCW-1:0] disc_cnt;
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      disc_cnt     <= '0;
      disconnected <= 1'b0;
    end else if (sbrx_s) begin
      disc_cnt     <= '0;
      disconnected <= 1'b0;
    end else if (disc_cnt != DCW'(DISC_CYCLES)) begin
      disc_cnt <= disc_cnt + 1'b1;
      if (disc_cnt == DCW'(DISC_CYCLES - 1)) disconnected <= 1'b1;
    end

  // bit layer
  typedef enum logic [1:0] {BIT_IDLE, BIT_DATA, BIT_STOP, BIT_WAIT} bit_st_t;
  bit_st_t    bst;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       sym_valid, ferr;
  logic [7:0] sym;

  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      bst   <= BIT_IDLE;
      bcnt  <= '0;
      shreg <= '0;
    end else if (disconnected) begin
      bst <= BIT_IDLE;
    end else begin
      case (bst)
        BIT_IDLE: if (!sbrx_s) begin bst <= BIT_DATA; bcnt <= '0; end
        BIT_DATA: begin
          shreg <= {sbrx_s, shreg[7:1]};
          bcnt  <= bcnt + 3'd1;
          if (bcnt == 3'd7) bst <= BIT_STOP;
        end
        BIT_STOP: bst <= sbrx_s ? BIT_IDLE : BIT_WAIT;
        default:  if (sbrx_s) bst <= BIT_IDLE;
      endcase
    end

  // Symbol strobes are combinational off the bit state so the frame decision
  // lands in the output register right behind the synchronizer.
  // A bad stop bit is reported when the line returns high: a line held low
  // long enough becomes a disconnect, which forces BIT_IDLE and is silent.
  assign sym       = shreg;
  assign sym_valid = (bst == BIT_STOP) && sbrx_s && !disconnected;
  assign ferr      = (bst == BIT_WAIT) && sbrx_s && !disconnected;

  // symbol FSM
  typedef enum logic [3:0] {WAIT_DLE1, WAIT_TYPE, WAIT_CLSE, AT_ADDR, AT_LEN,
                            AT_DATA, AT_CRC_HI, AT_CRC_LO, WAIT_DLE2, WAIT_ETX} st_t;
  st_t         st;
  logic [2:0]  typ_sh;
  logic [7:0]  addr_sh, len_sh;
  logic [23:0] data_sh;
  logic [1:0]  n_sh, idx;
  logic [6:0]  n_len;
  logic        crc_ok;

  // reads carry no data; responses and writes carry len[6:0] bytes
  assign n_len = ((typ_sh == TR_RSP) || sym[7]) ? sym[6:0] : 7'd0;

`ifdef SB_RX_CRC_CHECK_EN
  logic [15:0] crc_acc, crc_rx;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
    return r;
  endfunction

  // covers STX through the last data byte; restarted on every type symbol
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      crc_acc <= 16'hFFFF;
      crc_rx  <= '0;
    end else if (sym_valid) begin
      case (st)
        WAIT_TYPE:                 crc_acc <= crc16_upd(16'hFFFF, sym);
        AT_ADDR, AT_LEN, AT_DATA:  crc_acc <= crc16_upd(crc_acc, sym);
        AT_CRC_HI:                 crc_rx[15:8] <= sym;
        AT_CRC_LO:                 crc_rx[7:0]  <= sym;
        default: ;
      endcase
    end
  assign crc_ok = (crc_acc == crc_rx);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      st         <= WAIT_DLE1;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      trans_rcvd <= '0;
      rx_addr    <= '0;
      rx_len     <= '0;
      rx_data    <= '0;
      typ_sh     <= '0;
      addr_sh    <= '0;
      len_sh     <= '0;
      data_sh    <= '0;
      n_sh       <= '0;
      idx        <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (disconnected) begin
        st <= WAIT_DLE1;
      end else if (ferr) begin
        if (st != WAIT_DLE1) begin rx_err <= 1'b1; st <= WAIT_DLE1; end
      end else if (sym_valid) begin
        case (st)
          WAIT_DLE1: if (sym == SYM_DLE) st <= WAIT_TYPE;
          WAIT_TYPE:
            if (sym == SYM_CMD)      begin typ_sh <= TR_CMD; st <= AT_ADDR; end
            else if (sym == SYM_RSP) begin typ_sh <= TR_RSP; st <= AT_ADDR; end
            else if (sym == SYM_LSE) st <= WAIT_CLSE;
            else begin rx_err <= 1'b1; st <= WAIT_DLE1; end
          WAIT_CLSE: begin
            if (sym == SYM_CLSE) begin rx_valid <= 1'b1; trans_rcvd <= TR_LT; end
            else rx_err <= 1'b1;
            st <= WAIT_DLE1;
          end
          AT_ADDR: begin addr_sh <= sym; st <= AT_LEN; end
          AT_LEN: begin
            len_sh  <= sym;
            data_sh <= '0;
            idx     <= '0;
            n_sh    <= n_len[1:0];
            if (n_len > 7'd3)       begin rx_err <= 1'b1; st <= WAIT_DLE1; end
            else if (n_len == 7'd0) st <= AT_CRC_HI;
            else                    st <= AT_DATA;
          end
          AT_DATA: begin
            case (idx)
              2'd0:    data_sh[7:0]   <= sym;
              2'd1:    data_sh[15:8]  <= sym;
              default: data_sh[23:16] <= sym;
            endcase
            idx <= idx + 2'd1;
            if (idx == n_sh - 2'd1) st <= AT_CRC_HI;
          end
          AT_CRC_HI: st <= AT_CRC_LO;
          AT_CRC_LO: st <= WAIT_DLE2;
          WAIT_DLE2:
            if (sym == SYM_DLE) st <= WAIT_ETX;
            else begin rx_err <= 1'b1; st <= WAIT_DLE1; end
          WAIT_ETX: begin
            if (sym == SYM_ETX && crc_ok) begin
              rx_valid   <= 1'b1;
              trans_rcvd <= typ_sh;
              rx_addr    <= addr_sh;
              rx_len     <= len_sh;
              rx_data    <= data_sh;
            end else begin
              rx_err <= 1'b1;
            end
            st <= WAIT_DLE1;
          end
          default: st <= WAIT_DLE1;
        endcase
      end
    end
endmodule

// File: tb/tb_sb_trans_rx_fsm.sv
module tb_sb_trans_rx_fsm;
  localparam int DISC = 32;
  localparam int NV   = 13;
`ifdef SB_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        sb_clk = 1'b0;
  logic        rst    = 1'b0;
  logic        sbrx   = 1'b1;
  logic [2:0]  trans_rcvd;
  logic        rx_valid, rx_err, disconnected;
  logic [7:0]  rx_addr, rx_len;
  logic [23:0] rx_data;

  sb_trans_rx_fsm #(.DISC_CYCLES(DISC)) dut (
    .sb_clk(sb_clk), .rst(rst), .sbrx(sbrx), .trans_rcvd(trans_rcvd),
    .rx_valid(rx_valid), .rx_addr(rx_addr), .rx_len(rx_len), .rx_data(rx_data),
    .rx_err(rx_err), .disconnected(disconnected));

  always #5 sb_clk = ~sb_clk;

  typedef struct {
    logic [11:0][7:0] s;
    int          n;
    int          bad;    // symbol index sent with stop bit 0, -1 none
    logic        e_err;
    logic        e_at;
    logic [2:0]  e_tr;
    logic [7:0]  e_ad, e_ln;
    logic [23:0] e_dt;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_at;
    logic [2:0]  tr;
    logic [7:0]  ad, ln;
    logic [23:0] dt;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[NV];
  int   n_chk = 0, n_fail = 0;
  // last accepted frame, which the outputs must hold across errors
  logic [2:0]  lg_tr = '0;
  logic [7:0]  lg_ad = '0, lg_ln = '0;
  logic [23:0] lg_dt = '0;
  logic        lg_at = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic vec_t at(input logic [7:0] typ, input logic [7:0] ad, input logic [7:0] ln,
                              input logic [23:0] d, input int nd, input bit flip);
    vec_t v;
    logic [15:0] c;
    int k;
    v.s = '0;
    c = crc16(16'hFFFF, typ);
    c = crc16(c, ad);
    c = crc16(c, ln);
    v.s[0] = 8'hFE; v.s[1] = typ; v.s[2] = ad; v.s[3] = ln;
    k = 4;
    for (int j = 0; j < nd; j++) begin
      v.s[k] = d[8*j +: 8];
      c = crc16(c, d[8*j +: 8]);
      k++;
    end
    if (flip) c[0] = ~c[0];
    v.s[k] = c[15:8]; v.s[k+1] = c[7:0]; v.s[k+2] = 8'hFE; v.s[k+3] = 8'h40;
    v.n = k + 4;
    v.bad = -1;
    v.e_err = flip && CRC_ON;
    v.e_at = 1'b1;
    v.e_tr = (typ == 8'h05) ? 3'd2 : 3'd3;
    v.e_ad = ad; v.e_ln = ln; v.e_dt = d;
    return v;
  endfunction

  function automatic vec_t raw(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input int bad, input logic err);
    vec_t v;
    v.s = '0;
    v.s[0] = b0; v.s[1] = b1; v.s[2] = b2; v.s[3] = b3;
    v.n = n; v.bad = bad; v.e_err = err; v.e_at = 1'b0;
    v.e_tr = 3'd4; v.e_ad = '0; v.e_ln = '0; v.e_dt = '0;
    return v;
  endfunction

  task automatic send_sym(input logic [7:0] b, input logic stop);
    sbrx = 1'b0; @(negedge sb_clk);
    for (int i = 0; i < 8; i++) begin sbrx = b[i]; @(negedge sb_clk); end
    sbrx = stop; @(negedge sb_clk);
    sbrx = 1'b1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    if (v.e_err) begin
      e.err = 1'b1; e.chk_at = lg_at; e.tr = lg_tr; e.ad = lg_ad; e.ln = lg_ln; e.dt = lg_dt;
    end else begin
      e.err = 1'b0; e.chk_at = v.e_at; e.tr = v.e_tr; e.ad = v.e_ad; e.ln = v.e_ln; e.dt = v.e_dt;
      lg_tr = v.e_tr;
      lg_at = v.e_at;
      if (v.e_at) begin lg_ad = v.e_ad; lg_ln = v.e_ln; lg_dt = v.e_dt; end
    end
    sbq.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    push_exp(v);
    for (int i = 0; i < v.n; i++) send_sym(v.s[i], (i == v.bad) ? 1'b0 : 1'b1);
    if (v.bad >= 0) repeat (2) @(negedge sb_clk);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 80) begin @(negedge sb_clk); t++; end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d frame reports still pending, expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic reset_state_chk(input string tag);
    chk({tag, "_trans"}, 32'(trans_rcvd), 0);
    chk({tag, "_valid"}, 32'(rx_valid), 0);
    chk({tag, "_err"},   32'(rx_err), 0);
    chk({tag, "_addr"},  32'(rx_addr), 0);
    chk({tag, "_len"},   32'(rx_len), 0);
    chk({tag, "_data"},  32'(rx_data), 0);
    chk({tag, "_disc"},  32'(disconnected), 0);
  endtask

  // scoreboard side: every pulse pops one expected report
  always @(negedge sb_clk) begin
    if (rst && (rx_valid || rx_err)) begin
      chk("valid_err_exclusive", 32'(rx_valid & rx_err), 0);
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected no report", rx_valid, rx_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("kind", {30'd0, rx_err, rx_valid}, e.err ? 32'd2 : 32'd1);
        chk("trans_rcvd", 32'(trans_rcvd), 32'(e.tr));
        if (e.chk_at) begin
          chk("rx_addr", 32'(rx_addr), 32'(e.ad));
          chk("rx_len",  32'(rx_len),  32'(e.ln));
          chk("rx_data", 32'(rx_data), 32'(e.dt));
        end
      end
    end
  end

  initial begin
    int lat;
    tbl[0]  = raw(4, 8'h55, 8'hFE, 8'h80, 8'h7F, -1, 1'b0);        // noise then LT
    tbl[1]  = at(8'h05, 8'h4E, 8'h03, 24'h000000, 0, 1'b0);         // read command
    tbl[2]  = at(8'h04, 8'h4E, 8'h03, 24'h332211, 3, 1'b0);         // read response
    tbl[3]  = at(8'h04, 8'h4E, 8'h03, 24'h332211, 3, 1'b1);         // bad CRC
    tbl[4]  = at(8'h05, 8'h10, 8'h82, 24'h00BBAA, 2, 1'b0);         // write command
    tbl[5]  = at(8'h04, 8'h20, 8'h01, 24'h0000C3, 1, 1'b0);         // unused bytes zero
    tbl[6]  = raw(4, 8'hFE, 8'h04, 8'h4E, 8'h05, -1, 1'b1);        // length 5
    tbl[7]  = raw(2, 8'hFE, 8'h33, 8'h00, 8'h00, -1, 1'b1);        // bad type
    tbl[8]  = raw(3, 8'hFE, 8'h04, 8'h4E, 8'h00, 2, 1'b1);         // stop bit 0
    tbl[9]  = raw(3, 8'hFE, 8'h80, 8'h12, 8'h00, -1, 1'b1);        // bad CLSE
    tbl[10] = at(8'h05, 8'h4E, 8'h03, 24'h000000, 0, 1'b0);
    tbl[10].s[6] = 8'hFD; tbl[10].e_err = 1'b1;                     // bad second DLE
    tbl[11] = raw(3, 8'hFE, 8'h80, 8'h7F, 8'h00, -1, 1'b0);
    tbl[12] = at(8'h04, 8'h7E, 8'h00, 24'h000000, 0, 1'b0);         // empty response

    repeat (3) @(negedge sb_clk);
    reset_state_chk("reset");
    rst = 1'b1;
    repeat (3) @(negedge sb_clk);

    // LT with latency: stop bit of CLSE to rx_valid is 3 cycles
    push_exp(raw(3, 8'hFE, 8'h80, 8'h7F, 8'h00, -1, 1'b0));
    send_sym(8'hFE, 1'b1);
    send_sym(8'h80, 1'b1);
    send_sym(8'h7F, 1'b1);
    lat = 1;
    while (!rx_valid && lat < 12) begin @(negedge sb_clk); lat++; end
    chk("latency", 32'(lat), 3);
    drain("lt_drain");

    // table, back-to-back with 0..2 idle bits between frames
    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i]);
      repeat ($urandom_range(0, 2)) @(negedge sb_clk);
    end
    drain("table_drain");

    // disconnect mid-frame
    send_sym(8'hFE, 1'b1);
    send_sym(8'h05, 1'b1);
    sbrx = 1'b0;
    repeat (DISC + 1) @(negedge sb_clk);
    chk("disc_before", 32'(disconnected), 0);
    @(negedge sb_clk);
    chk("disc_asserted", 32'(disconnected), 1);
    repeat (6) @(negedge sb_clk);
    chk("disc_held", 32'(disconnected), 1);
    sbrx = 1'b1;
    repeat (4) @(negedge sb_clk);
    chk("disc_released", 32'(disconnected), 0);
    run_vec(tbl[2]);
    drain("disc_drain");

    // reset mid-frame discards silently and clears outputs
    send_sym(8'hFE, 1'b1);
    send_sym(8'h05, 1'b1);
    send_sym(8'h4E, 1'b1);
    rst = 1'b0;
    @(negedge sb_clk);
    reset_state_chk("midreset");
    rst = 1'b1;
    lg_tr = '0; lg_ad = '0; lg_ln = '0; lg_dt = '0; lg_at = 1'b1;
    repeat (2) @(negedge sb_clk);
    run_vec(tbl[11]);
    run_vec(tbl[4]);
    drain("midreset_drain");

    repeat (5) @(negedge sb_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
